// File: rtl/lc3_memory_ready_ctrl.sv
`timescale 1ns/1ps
// LC-3 memory access controller: sequences a fixed-latency memory access and produces the R bit.
// Define LC3_MMIO_EN to decode the xFExx page to the keyboard/display device registers.
module lc3_memory_ready_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_Reset_n,
  input  logic              i_MIO_EN,
  input  logic              i_R_W,
  input  logic [ADDR_W-1:0] i_MAR,
  input  logic [DATA_W-1:0] i_MDR,
  output logic              o_Ready,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_kbd_valid,
  input  logic [7:0]        i_kbd_data,
  output logic              o_kbd_ack,
  input  logic              i_dsr_ready,
  output logic [7:0]        o_ddr_data,
  output logic              o_ddr_valid
);

  localparam int         WAIT_CL = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              wr_r;
  logic              dev_r;
  logic              abort_r;
  logic              dev_hit_s;
  logic              last_s;
  logic              complete_s;
  logic [DATA_W-1:0] rd_data_s;

  // Final ACCESS cycle; the request completes only if MIO_EN was never seen low.
  assign last_s     = (state_r == ACCESS) && (cnt_r == 4'd1);
  assign complete_s = last_s && !abort_r && i_MIO_EN;

`ifdef LC3_MMIO_EN
  function automatic logic is_dev_page(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:8] == (ADDR_W-8)'(8'hFE));
  endfunction

  assign dev_hit_s = is_dev_page(i_MAR);

  // Read-data source: device register file for the xFExx page, memory otherwise
  always_comb begin
    rd_data_s = i_mem_rdata;
    if (dev_r) begin
      case (o_mem_addr[7:0])
        8'h00:   rd_data_s = {i_kbd_valid, {(DATA_W-1){1'b0}}};
        8'h02:   rd_data_s = {{(DATA_W-8){1'b0}}, i_kbd_data};
        8'h04:   rd_data_s = {i_dsr_ready, {(DATA_W-1){1'b0}}};
        default: rd_data_s = {DATA_W{1'b0}};
      endcase
    end else begin
      rd_data_s = i_mem_rdata;
    end
  end

  // Device side effects: KBDR read acknowledge and DDR write, both visible during DONE
  always_ff @(posedge i_clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_kbd_ack   <= 1'b0;
      o_ddr_valid <= 1'b0;
      o_ddr_data  <= 8'h00;
    end else begin
      o_kbd_ack   <= complete_s && dev_r && !wr_r && (o_mem_addr[7:0] == 8'h02);
      o_ddr_valid <= complete_s && dev_r &&  wr_r && (o_mem_addr[7:0] == 8'h06);
      if (complete_s && dev_r && wr_r && (o_mem_addr[7:0] == 8'h06)) begin
        o_ddr_data <= o_mem_wdata[7:0];
      end else begin
        o_ddr_data <= o_ddr_data;
      end
    end
  end
`else
  assign dev_hit_s   = 1'b0;
  assign rd_data_s   = i_mem_rdata;
  assign o_kbd_ack   = 1'b0;
  assign o_ddr_valid = 1'b0;
  assign o_ddr_data  = 8'h00;

  logic unused_dev_s;
  assign unused_dev_s = ^{i_kbd_valid, i_kbd_data, i_dsr_ready, dev_r};
`endif

  // Access sequencer: IDLE -> ACCESS -> DONE -> IDLE, with all bus and ready outputs registered
  always_ff @(posedge i_clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      wr_r        <= 1'b0;
      dev_r       <= 1'b0;
      abort_r     <= 1'b0;
      o_Ready     <= 1'b0;
      o_mem_data  <= {DATA_W{1'b0}};
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= {ADDR_W{1'b0}};
      o_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      o_Ready  <= 1'b0;
      o_mem_we <= 1'b0;
      case (state_r)
        IDLE: begin
          o_mem_req <= 1'b0;
          if (i_MIO_EN) begin
            state_r     <= ACCESS;
            o_mem_addr  <= i_MAR;
            o_mem_wdata <= i_MDR;
            wr_r        <= i_R_W;
            dev_r       <= dev_hit_s;
            abort_r     <= 1'b0;
            cnt_r       <= dev_hit_s ? 4'd1 : WAIT_LD;
            o_mem_req   <= !dev_hit_s;
            o_mem_we    <= i_R_W && !dev_hit_s;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == 4'd1) begin
            cnt_r     <= 4'd0;
            abort_r   <= 1'b0;
            o_mem_req <= 1'b0;
            // An abandoned access still finishes on the bus but never raises R.
            if (complete_s) begin
              state_r <= DONE;
              o_Ready <= 1'b1;
              if (!wr_r) begin
                o_mem_data <= rd_data_s;
              end else begin
                o_mem_data <= o_mem_data;
              end
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            abort_r <= abort_r || !i_MIO_EN;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          o_mem_req <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 4'd0;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_memory_ready_ctrl.sv
`timescale 1ns/1ps
// Bench for lc3_memory_ready_ctrl: directed vector table, abort and reset sequences,
// and randomized traffic checked against a timestamp-based access model.
module tb_lc3_memory_ready_ctrl;
  localparam int W = 4;

  typedef struct packed {
    logic        mio;
    logic        rw;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        req;
    logic        we;
    logic        rdy;
    logic [15:0] data;
    logic [15:0] addr;
    logic [15:0] wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mio = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr = 16'h0000;
  logic        ready;
  logic [15:0] mem_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_ack;
  logic        dsr_ready = 1'b0;
  logic [7:0]  ddr_data;
  logic        ddr_valid;

  int n_vec = 0;
  int n_miss = 0;
  int age = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:15];
  vec_t tbl [24];

  lc3_memory_ready_ctrl #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
    .i_clk(clk), .i_Reset_n(rst_n), .i_MIO_EN(mio), .i_R_W(rw), .i_MAR(mar), .i_MDR(mdr),
    .o_Ready(ready), .o_mem_data(mem_data), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_kbd_valid(kbd_valid), .i_kbd_data(kbd_data), .o_kbd_ack(kbd_ack),
    .i_dsr_ready(dsr_ready), .o_ddr_data(ddr_data), .o_ddr_valid(ddr_valid)
  );

  always #5 clk = ~clk;

  // Memory array: data is valid only in the cycle W cycles after the request rises.
  always @(posedge clk) begin
    #1;
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_req) age = age + 1;
    else age = 0;
    mem_rdata = (age == W) ? mem[mem_addr] : 16'hDEAD;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running after %0d checks, expected to finish", n_vec);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_dev0();
    chk1("kbd_ack", kbd_ack, 1'b0);
    chk1("ddr_valid", ddr_valid, 1'b0);
    chk("ddr_data", {8'h00, ddr_data}, 16'h0000);
  endtask

  task automatic drive(input logic m, input logic r, input logic [15:0] a, input logic [15:0] d);
    mio = m; rw = r; mar = a; mdr = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic m, input logic r, input logic [15:0] a, input logic [15:0] d,
                              input logic q, input logic e, input logic y,
                              input logic [15:0] dt, input logic [15:0] ad, input logic [15:0] wd);
    vec_t v;
    v.mio = m; v.rw = r; v.mar = a; v.mdr = d;
    v.req = q; v.we = e; v.rdy = y; v.data = dt; v.addr = ad; v.wdata = wd;
    return v;
  endfunction

  // Randomized-phase reference model state (edge-indexed timestamps).
  int          m_start;
  int          m_idle;
  logic        m_ab;
  logic        m_rw;
  logic [15:0] m_addr, m_wdata, m_data;
  logic        m_dk;
  logic        r_mio, r_rw;
  logic [15:0] r_mar, r_mdr;

  initial begin
    // Read, write, then back-to-back reads with MIO_EN held; inputs during ACCESS/DONE are ignored.
    tbl[0]  = mk(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b1, 16'h3005, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h0000);
    tbl[2]  = mk(1'b1, 1'b1, 16'h3005, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h0000);
    tbl[3]  = mk(1'b1, 1'b1, 16'h3005, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h0000);
    tbl[4]  = mk(1'b1, 1'b1, 16'h3005, 16'hAAAA, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3000, 16'h0000);
    tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h3000, 16'h0000);
    tbl[6]  = mk(1'b1, 1'b1, 16'h3001, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h3001, 16'hBEEF);
    tbl[7]  = mk(1'b1, 1'b0, 16'h3007, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'hBEEF);
    tbl[8]  = mk(1'b1, 1'b0, 16'h3007, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'hBEEF);
    tbl[9]  = mk(1'b1, 1'b0, 16'h3007, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'hBEEF);
    tbl[10] = mk(1'b1, 1'b0, 16'h3007, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3001, 16'hBEEF);
    tbl[11] = mk(1'b1, 1'b0, 16'h3000, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'hBEEF);
    tbl[12] = mk(1'b1, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'h5555);
    tbl[13] = mk(1'b1, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'h5555);
    tbl[14] = mk(1'b1, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'h5555);
    tbl[15] = mk(1'b1, 1'b0, 16'h3001, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h3001, 16'h5555);
    tbl[16] = mk(1'b1, 1'b0, 16'h3001, 16'h5555, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h3001, 16'h5555);
    tbl[17] = mk(1'b1, 1'b0, 16'h3000, 16'h6666, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h3001, 16'h5555);
    tbl[18] = mk(1'b1, 1'b0, 16'h3000, 16'h6666, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h3000, 16'h6666);
    tbl[19] = mk(1'b1, 1'b0, 16'h3000, 16'h6666, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h3000, 16'h6666);
    tbl[20] = mk(1'b1, 1'b0, 16'h3000, 16'h6666, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h3000, 16'h6666);
    tbl[21] = mk(1'b1, 1'b0, 16'h3000, 16'h6666, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h3000, 16'h6666);
    tbl[22] = mk(1'b1, 1'b0, 16'h3000, 16'h6666, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3000, 16'h6666);
    tbl[23] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h3000, 16'h6666);

    mem[16'h3000] = 16'h1234;
    mem[16'h3002] = 16'h7777;

    // Reset state
    cyc();
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_data", mem_data, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk_dev0();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].mio, tbl[i].rw, tbl[i].mar, tbl[i].mdr);
      cyc();
      chk1($sformatf("tbl%0d_req", i), mem_req, tbl[i].req);
      chk1($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
      chk1($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_data", i), mem_data, tbl[i].data);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].wdata);
      chk_dev0();
    end

    // MIO_EN drops in ACCESS cycle 2: bus access completes, no Ready, straight back to IDLE
    drive(1'b1, 1'b0, 16'h3002, 16'h0000); cyc();
    chk1("abort_req_c1", mem_req, 1'b1);
    chk("abort_addr", mem_addr, 16'h3002);
    cyc();
    chk1("abort_req_c2", mem_req, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc();
    chk1("abort_req_c3", mem_req, 1'b1);
    cyc();
    chk1("abort_req_c4", mem_req, 1'b1);
    chk1("abort_ready_c4", ready, 1'b0);
    cyc();
    chk1("abort_req_end", mem_req, 1'b0);
    chk1("abort_no_ready", ready, 1'b0);
    drive(1'b1, 1'b0, 16'h3000, 16'h0000);
    cyc();
    chk1("abort_restart_req", mem_req, 1'b1);
    chk1("abort_restart_ready", ready, 1'b0);
    chk("abort_restart_addr", mem_addr, 16'h3000);
    for (int k = 0; k < W - 1; k++) begin
      cyc();
      chk1("abort_restart_busy", mem_req, 1'b1);
    end
    cyc();
    chk1("abort_restart_done", ready, 1'b1);
    chk("abort_restart_data", mem_data, 16'h1234);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc();
    chk1("abort_restart_idle", ready, 1'b0);

    // Reset asserted in ACCESS cycle 2
    drive(1'b1, 1'b0, 16'h3000, 16'h0000);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_req", mem_req, 1'b0);
    chk1("midrst_we", mem_we, 1'b0);
    chk1("midrst_ready", ready, 1'b0);
    chk("midrst_data", mem_data, 16'h0000);
    chk("midrst_addr", mem_addr, 16'h0000);
    chk_dev0();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 16'($urandom);
      mem[16'h3000 + 16'(k)] = ref_mem[k];
    end
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk1("postrst_ready", ready, 1'b0);
      chk1("postrst_req", mem_req, 1'b0);
    end

    // Randomized traffic against the timestamp model
    m_start = -100; m_idle = 0; m_ab = 1'b0; m_rw = 1'b0;
    m_addr = 16'h0000; m_wdata = 16'h0000; m_data = 16'h0000; m_dk = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r_mio = ($urandom_range(0, 99) < 80);
      r_rw  = 1'($urandom_range(0, 1));
      r_mar = 16'h3000 + 16'($urandom_range(0, 15));
      r_mdr = 16'($urandom);
      drive(r_mio, r_rw, r_mar, r_mdr);
      cyc();
      if (n >= m_idle && r_mio) begin
        m_start = n; m_ab = 1'b0; m_rw = r_rw; m_addr = r_mar; m_wdata = r_mdr;
        m_idle = n + W + 2;
        if (r_rw) ref_mem[r_mar[3:0]] = r_mdr;
      end else if (n > m_start && n <= m_start + W && !r_mio) begin
        m_ab = 1'b1;
        m_idle = m_start + W + 1;
      end
      if (n == m_start + W && !m_rw) begin
        if (!m_ab) begin
          m_data = ref_mem[m_addr[3:0]];
          m_dk = 1'b1;
        end else begin
          m_dk = 1'b0;
        end
      end
      chk1("rnd_req", mem_req, (n >= m_start) && (n < m_start + W));
      chk1("rnd_we", mem_we, (n == m_start) && m_rw);
      chk1("rnd_ready", ready, (n == m_start + W) && !m_ab);
      chk("rnd_addr", mem_addr, m_addr);
      chk("rnd_wdata", mem_wdata, m_wdata);
      if (m_dk) chk("rnd_data", mem_data, m_data);
      chk_dev0();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < W + 3; k++) cyc();

`ifdef LC3_MMIO_EN
    // Device registers: KBSR then KBDR read, then DDR write; memory bus stays quiet
    kbd_valid = 1'b1; kbd_data = 8'h41; dsr_ready = 1'b1;
    drive(1'b1, 1'b0, 16'hFE00, 16'h0000); cyc();
    chk1("kbsr_req", mem_req, 1'b0);
    chk1("kbsr_ready_early", ready, 1'b0);
    cyc();
    chk1("kbsr_ready", ready, 1'b1);
    chk("kbsr_data", mem_data, 16'h8000);
    chk1("kbsr_req_done", mem_req, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000); cyc();
    chk1("kbsr_idle", ready, 1'b0);
    drive(1'b1, 1'b0, 16'hFE02, 16'h0000); cyc();
    chk1("kbdr_req", mem_req, 1'b0);
    cyc();
    chk1("kbdr_ready", ready, 1'b1);
    chk("kbdr_data", mem_data, 16'h0041);
    chk1("kbdr_ack", kbd_ack, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000); cyc();
    chk1("kbdr_ack_end", kbd_ack, 1'b0);
    drive(1'b1, 1'b1, 16'hFE06, 16'h0052); cyc();
    chk1("ddr_we", mem_we, 1'b0);
    chk1("ddr_req", mem_req, 1'b0);
    cyc();
    chk1("ddr_ready", ready, 1'b1);
    chk1("ddr_valid_pulse", ddr_valid, 1'b1);
    chk("ddr_char", {8'h00, ddr_data}, 16'h0052);
    chk("ddr_data_kept", mem_data, 16'h0041);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000); cyc();
    chk1("ddr_valid_end", ddr_valid, 1'b0);
    chk("ddr_char_held", {8'h00, ddr_data}, 16'h0052);
`else
    // Without device decode the xFExx page is ordinary memory
    mem[16'hFE00] = 16'h4242;
    drive(1'b1, 1'b0, 16'hFE00, 16'h0000); cyc();
    chk1("fe00_mem_req", mem_req, 1'b1);
    for (int k = 0; k < W - 1; k++) cyc();
    cyc();
    chk1("fe00_ready", ready, 1'b1);
    chk("fe00_data", mem_data, 16'h4242);
    chk_dev0();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000); cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
